// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} for the HI/LO write. Operands are latched on
// the accepting edge and the result is presented one edge after the FSM
// enters END, which gives a total of DATA_W+2 edges from start to ready.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] res;
    if (neg) begin
      res = (~v) + DATA_ONE;
    end else begin
      res = v;
    end
    return res;
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2*DATA_W:0]      r_work, w_work_nxt;
  logic [DATA_W-1:0]      r_divisor, w_divisor_nxt;
  logic                   r_neg_a, w_neg_a_nxt;
  logic                   r_neg_b, w_neg_b_nxt;
  logic [2*DATA_W-1:0]    r_res, w_res_nxt;
  logic [2*DATA_W-1:0]    w_result_nxt;
  logic                   w_ready_nxt;

  logic [DATA_W:0]        w_diff;
  logic                   w_op1_neg, w_op2_neg;
  logic [DATA_W-1:0]      w_quot, w_rem;

  // Trial subtraction of the divisor from the upper partial remainder.
  assign w_diff    = r_work[2*DATA_W:DATA_W] - {1'b0, r_divisor};
  // Operand signs only matter for the signed variant.
  assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  // Sign fix-up: quotient follows sign mismatch, remainder follows dividend.
  assign w_quot    = cond_neg(r_neg_a ^ r_neg_b, r_work[DATA_W-1:0]);
  assign w_rem     = cond_neg(r_neg_a, r_work[2*DATA_W:DATA_W+1]);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_a_nxt   = r_neg_a;
    w_neg_b_nxt   = r_neg_b;
    w_res_nxt     = r_res;
    w_result_nxt  = '0;
    w_ready_nxt   = 1'b0;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt   = S_ON;
            w_cnt_nxt     = '0;
            w_neg_a_nxt   = w_op1_neg;
            w_neg_b_nxt   = w_op2_neg;
            w_work_nxt    = {{DATA_W{1'b0}}, cond_neg(w_op1_neg, opdata1_i), 1'b0};
            w_divisor_nxt = cond_neg(w_op2_neg, opdata2_i);
          end
        end else begin
          w_state_nxt = S_FREE;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
        end else begin
          w_state_nxt = S_END;
          w_res_nxt   = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_DONE) begin
          if (w_diff[DATA_W]) begin
            w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_state_nxt = S_END;
          w_cnt_nxt   = '0;
          w_res_nxt   = {w_rem, w_quot};
        end
      end
      S_END: begin
        if (start_i) begin
          w_ready_nxt  = 1'b1;
          w_result_nxt = r_res;
        end else begin
          w_state_nxt  = S_FREE;
        end
      end
      default: begin
        w_state_nxt = S_FREE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_res     <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_a   <= w_neg_a_nxt;
      r_neg_b   <= w_neg_b_nxt;
      r_res     <= w_res_nxt;
      result_o  <= w_result_nxt;
      ready_o   <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_err = 0;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .Rst_n        (Rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Run-time guard in case the sequence stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
  endtask

  // Full operation: launch, measure latency, check result, hold, drop start.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    lat = 999;
    launch(sgn, a, b);
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (e == 1) begin
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        lat = e - 1;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp);
    tick();
    chk({tag, " hold ready"}, {63'd0, ready_o}, 64'd1);
    chk({tag, " hold result"}, result_o, exp);
    annul_i = 1'b1;
    tick();
    chk({tag, " annul in END ignored"}, {63'd0, ready_o}, 64'd1);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk({tag, " drop ready"}, {63'd0, ready_o}, 64'd0);
    chk({tag, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    int highs;
    Rst_n        = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) tick();
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    Rst_n = 1'b1;
    tick();

    do_op("divu 7/2",        1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 34);
    do_op("div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 34);
    do_op("div 7/-2",        1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 34);
    do_op("divu max/1",      1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 34);
    do_op("div overflow",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 34);
    do_op("divu fff9/2",     1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 34);
    do_op("div -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 34);
    do_op("div 5/0",         1'b1, 32'd5,          32'd0,          64'h00000000_00000000, 2);

    // annul held together with start in FREE keeps the divider idle.
    launch(1'b0, 32'd100, 32'd7);
    annul_i = 1'b1;
    repeat (3) tick();
    chk("annul free ready", {63'd0, ready_o}, 64'd0);
    do_op("after free annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    // annul in BYZERO aborts the by-zero path.
    launch(1'b1, 32'd5, 32'd0);
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready_o) highs++;
    end
    chk("byzero annul no ready", 64'(highs), 64'd0);

    // annul sampled while the iteration counter holds 10.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (11) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) highs++;
    end
    chk("on annul no ready", 64'(highs), 64'd0);
    do_op("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    // Reset sampled while the iteration counter holds 20.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (21) tick();
    Rst_n   = 1'b0;
    start_i = 1'b0;
    tick();
    chk("mid reset ready", {63'd0, ready_o}, 64'd0);
    chk("mid reset result", result_o, 64'd0);
    Rst_n = 1'b1;
    do_op("divu 1000/3", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
